// File: rtl/exe_stage.sv
// Execute stage of a four-lane 16-bit SIMD pipeline.
// Single-cycle ALU ops complete in one edge. MUL runs as a 4-step nibble-serial
// multiply, and stall_out holds the ID/EXE register while the multiply runs.
module exe_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        stop_in,
    input  logic        regWrite_in,
    input  logic        memWrite_in,
    input  logic        branch_in,
    input  logic        resultSrc_in,
    input  logic [3:0]  rd_in,
    input  logic [3:0]  aluControl_in,
    input  logic [15:0] op01_in,
    input  logic [15:0] op11_in,
    input  logic [15:0] op21_in,
    input  logic [15:0] op31_in,
    input  logic [15:0] op02_in,
    input  logic [15:0] op12_in,
    input  logic [15:0] op22_in,
    input  logic [15:0] op32_in,
    output logic [15:0] res0_out,
    output logic [15:0] res1_out,
    output logic [15:0] res2_out,
    output logic [15:0] res3_out,
    output logic [3:0]  rd_out,
    output logic        regWrite_out,
    output logic        memWrite_out,
    output logic        resultSrc_out,
    output logic        branchTaken_out,
    output logic        zero_out,
    output logic        stall_out
);

    localparam logic [3:0] OpMul = 4'd9;

    typedef enum logic [0:0] {StIdle, StMul} state_e;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;

    // Operands and control captured when a multiply starts
    logic [15:0] a_q   [4];
    logic [15:0] a_d   [4];
    logic [15:0] b_q   [4];
    logic [15:0] b_d   [4];
    logic [15:0] acc_q [4];
    logic [15:0] acc_d [4];
    logic [3:0]  cap_rd_q, cap_rd_d;
    logic        cap_rw_q, cap_rw_d;
    logic        cap_mw_q, cap_mw_d;
    logic        cap_rs_q, cap_rs_d;

    // Output registers
    logic [15:0] res_q [4];
    logic [15:0] res_d [4];
    logic [3:0]  rd_q, rd_d;
    logic        rw_q, rw_d;
    logic        mw_q, mw_d;
    logic        rs_q, rs_d;
    logic        bt_q, bt_d;
    logic        zero_q, zero_d;

    logic [15:0] op_a    [4];
    logic [15:0] op_b    [4];
    logic [15:0] alu_res [4];
    logic [15:0] acc_nxt [4];
    logic [3:0]  nib     [4];
    logic [15:0] prod    [4];
    logic        alu_zero;
    logic        mul_zero;

    // Single-cycle lane operations; opcode 9 is sequenced by the FSM instead.
    function automatic logic [15:0] lane_alu(input logic [3:0]  op,
                                             input logic [15:0] a,
                                             input logic [15:0] b);
        logic [3:0]  sh;
        logic [4:0]  rsh;
        logic [15:0] r;
        sh  = b[3:0];
        rsh = 5'd16 - {1'b0, sh};
        case (op)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = a & b;
            4'd3:    r = a | b;
            4'd4:    r = a ^ b;
            4'd5:    r = a << sh;
            4'd6:    r = a >> sh;
            // A shift by 16 yields 0, so sh == 0 degenerates cleanly to a
            4'd7:    r = (a << sh) | (a >> rsh);
            4'd8:    r = (a >> sh) | (a << rsh);
            4'd10:   r = a;
            4'd11:   r = b;
            4'd12:   r = (a == b) ? 16'hFFFF : 16'h0000;
            default: r = 16'h0000;
        endcase
        return r;
    endfunction

    // Lane operand fan-in, single-cycle results and multiply partial products
    always_comb begin
        op_a[0] = op01_in;
        op_a[1] = op11_in;
        op_a[2] = op21_in;
        op_a[3] = op31_in;
        op_b[0] = op02_in;
        op_b[1] = op12_in;
        op_b[2] = op22_in;
        op_b[3] = op32_in;
        for (int i = 0; i < 4; i++) begin
            alu_res[i] = lane_alu(aluControl_in, op_a[i], op_b[i]);
            nib[i]     = b_q[i][{cnt_q, 2'b00} +: 4];
            prod[i]    = a_q[i] * {12'd0, nib[i]};
            acc_nxt[i] = acc_q[i] + (prod[i] << {cnt_q, 2'b00});
        end
        alu_zero = (alu_res[0] == 16'h0) && (alu_res[1] == 16'h0) &&
                   (alu_res[2] == 16'h0) && (alu_res[3] == 16'h0);
        mul_zero = (acc_nxt[0] == 16'h0) && (acc_nxt[1] == 16'h0) &&
                   (acc_nxt[2] == 16'h0) && (acc_nxt[3] == 16'h0);
    end

    // Hold ID/EXE while a multiply is being issued or is still running
    always_comb begin
        stall_out = stop_in |
                    ((state_q == StIdle) && (aluControl_in == OpMul)) |
                    ((state_q == StMul) && (cnt_q != 2'd3));
    end

    // FSM next state, multiply datapath and output register updates
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cap_rd_d = cap_rd_q;
        cap_rw_d = cap_rw_q;
        cap_mw_d = cap_mw_q;
        cap_rs_d = cap_rs_q;
        rd_d     = rd_q;
        rw_d     = rw_q;
        mw_d     = mw_q;
        rs_d     = rs_q;
        bt_d     = bt_q;
        zero_d   = zero_q;
        for (int i = 0; i < 4; i++) begin
            a_d[i]   = a_q[i];
            b_d[i]   = b_q[i];
            acc_d[i] = acc_q[i];
            res_d[i] = res_q[i];
        end

        if (!stop_in) begin
            case (state_q)
                StIdle: begin
                    if (aluControl_in == OpMul) begin
                        for (int i = 0; i < 4; i++) begin
                            a_d[i]   = op_a[i];
                            b_d[i]   = op_b[i];
                            acc_d[i] = 16'h0;
                        end
                        cap_rd_d = rd_in;
                        cap_rw_d = regWrite_in;
                        cap_mw_d = memWrite_in;
                        cap_rs_d = resultSrc_in;
                        cnt_d    = 2'd0;
                        state_d  = StMul;
                        // Bubble: results, rd and resultSrc keep their values
                        rw_d     = 1'b0;
                        mw_d     = 1'b0;
                        bt_d     = 1'b0;
                    end else begin
                        for (int i = 0; i < 4; i++) begin
                            res_d[i] = alu_res[i];
                        end
                        rd_d   = rd_in;
                        rw_d   = regWrite_in;
                        mw_d   = memWrite_in;
                        rs_d   = resultSrc_in;
                        bt_d   = branch_in & (op01_in == op02_in);
                        zero_d = alu_zero;
                    end
                end
                StMul: begin
                    for (int i = 0; i < 4; i++) begin
                        acc_d[i] = acc_nxt[i];
                    end
                    if (cnt_q == 2'd3) begin
                        for (int i = 0; i < 4; i++) begin
                            res_d[i] = acc_nxt[i];
                        end
                        rd_d    = cap_rd_q;
                        rw_d    = cap_rw_q;
                        mw_d    = cap_mw_q;
                        rs_d    = cap_rs_q;
                        bt_d    = 1'b0;
                        zero_d  = mul_zero;
                        cnt_d   = 2'd0;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                        rw_d  = 1'b0;
                        mw_d  = 1'b0;
                        bt_d  = 1'b0;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = 2'd0;
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= 2'd0;
            cap_rd_q <= 4'd0;
            cap_rw_q <= 1'b0;
            cap_mw_q <= 1'b0;
            cap_rs_q <= 1'b0;
            rd_q     <= 4'd0;
            rw_q     <= 1'b0;
            mw_q     <= 1'b0;
            rs_q     <= 1'b0;
            bt_q     <= 1'b0;
            zero_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                a_q[i]   <= 16'h0;
                b_q[i]   <= 16'h0;
                acc_q[i] <= 16'h0;
                res_q[i] <= 16'h0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cap_rd_q <= cap_rd_d;
            cap_rw_q <= cap_rw_d;
            cap_mw_q <= cap_mw_d;
            cap_rs_q <= cap_rs_d;
            rd_q     <= rd_d;
            rw_q     <= rw_d;
            mw_q     <= mw_d;
            rs_q     <= rs_d;
            bt_q     <= bt_d;
            zero_q   <= zero_d;
            for (int i = 0; i < 4; i++) begin
                a_q[i]   <= a_d[i];
                b_q[i]   <= b_d[i];
                acc_q[i] <= acc_d[i];
                res_q[i] <= res_d[i];
            end
        end
    end

    assign res0_out        = res_q[0];
    assign res1_out        = res_q[1];
    assign res2_out        = res_q[2];
    assign res3_out        = res_q[3];
    assign rd_out          = rd_q;
    assign regWrite_out    = rw_q;
    assign memWrite_out    = mw_q;
    assign resultSrc_out   = rs_q;
    assign branchTaken_out = bt_q;
    assign zero_out        = zero_q;

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: expected outcomes are queued when an
// instruction is presented and popped when the stage retires it.
module tb_exe_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stop_in;
    logic        rw_in, mw_in, br_in, rs_in;
    logic [3:0]  rd_in, op_in;
    logic [63:0] a_v, b_v;
    logic [15:0] r0, r1, r2, r3;
    logic [3:0]  rd_o;
    logic        rw_o, mw_o, rs_o, bt_o, z_o, stall;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [63:0] res;
        logic [3:0]  rd;
        logic        rw;
        logic        mw;
        logic        rs;
        logic        bt;
        logic        z;
    } exp_t;

    exp_t sb_q[$];
    exp_t last;

    always #5 clk = ~clk;

    exe_stage dut (
        .clk             (clk),
        .reset           (reset),
        .stop_in         (stop_in),
        .regWrite_in     (rw_in),
        .memWrite_in     (mw_in),
        .branch_in       (br_in),
        .resultSrc_in    (rs_in),
        .rd_in           (rd_in),
        .aluControl_in   (op_in),
        .op01_in         (a_v[15:0]),
        .op11_in         (a_v[31:16]),
        .op21_in         (a_v[47:32]),
        .op31_in         (a_v[63:48]),
        .op02_in         (b_v[15:0]),
        .op12_in         (b_v[31:16]),
        .op22_in         (b_v[47:32]),
        .op32_in         (b_v[63:48]),
        .res0_out        (r0),
        .res1_out        (r1),
        .res2_out        (r2),
        .res3_out        (r3),
        .rd_out          (rd_o),
        .regWrite_out    (rw_o),
        .memWrite_out    (mw_o),
        .resultSrc_out   (rs_o),
        .branchTaken_out (bt_o),
        .zero_out        (z_o),
        .stall_out       (stall)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference lane operation; MUL given directly as a product
    function automatic logic [15:0] ref_op(input logic [3:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
        logic [31:0] w;
        logic [15:0] r;
        w = {a, a};
        case (op)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = a << b[3:0];
            4'd6:  r = a >> b[3:0];
            4'd7:  begin w = w << b[3:0]; r = w[31:16]; end
            4'd8:  begin w = w >> b[3:0]; r = w[15:0]; end
            4'd9:  r = a * b;
            4'd10: r = a;
            4'd11: r = b;
            4'd12: r = (a == b) ? 16'hFFFF : 16'h0000;
            default: r = 16'h0000;
        endcase
        return r;
    endfunction

    // Present one instruction as ID/EXE would: held while stall_out is high
    task automatic issue(input string tag, input logic [3:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic rw, input logic mw,
                         input logic br, input logic rs, input logic [3:0] rd,
                         input int stop_at, input int stop_len);
        exp_t e;
        exp_t got;
        int   edges;
        int   stalls;
        int   exp_lat;
        bit   done;
        logic st;
        op_in = op; a_v = a; b_v = b;
        rw_in = rw; mw_in = mw; br_in = br; rs_in = rs; rd_in = rd;
        for (int i = 0; i < 4; i++) e.res[16*i +: 16] = ref_op(op, a[16*i +: 16], b[16*i +: 16]);
        e.rd = rd; e.rw = rw; e.mw = mw; e.rs = rs;
        e.bt = (op != 4'd9) && br && (a[15:0] == b[15:0]);
        e.z  = (e.res == 64'h0);
        sb_q.push_back(e);
        exp_lat = ((op == 4'd9) ? 5 : 1) + stop_len;
        edges = 0; stalls = 0; done = 0;
        while (!done && edges < 40) begin
            stop_in = (stop_len > 0) && (edges >= stop_at) && (edges < stop_at + stop_len);
            #1;
            st = stall;
            if (st) stalls++;
            @(posedge clk);
            #1;
            edges++;
            if (!st) begin
                done = 1;
            end else begin
                check({tag, "_bubble_rw"}, {63'd0, rw_o}, 64'd0);
                check({tag, "_bubble_bt"}, {63'd0, bt_o}, 64'd0);
                check({tag, "_bubble_res"}, {r3, r2, r1, r0}, last.res);
            end
            @(negedge clk);
        end
        stop_in = 1'b0;
        check({tag, "_latency"}, 64'(edges), 64'(exp_lat));
        check({tag, "_stalls"}, 64'(stalls), 64'(exp_lat - 1));
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            got = sb_q.pop_front();
            check({tag, "_res"}, {r3, r2, r1, r0}, got.res);
            check({tag, "_ctl"}, {59'd0, rd_o, rw_o, mw_o, rs_o},
                  {59'd0, got.rd, got.rw, got.mw, got.rs});
            check({tag, "_bt"}, {63'd0, bt_o}, {63'd0, got.bt});
            check({tag, "_zero"}, {63'd0, z_o}, {63'd0, got.z});
            last = got;
        end
    endtask

    logic [3:0] ops [14] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8,
                             4'd10, 4'd11, 4'd12, 4'd13, 4'd15, 4'd0, 4'd1};

    initial begin
        logic [63:0] ra, rb;
        reset = 1'b0; stop_in = 1'b0;
        rw_in = 0; mw_in = 0; br_in = 0; rs_in = 0; rd_in = 0; op_in = 4'd0;
        a_v = '0; b_v = '0;
        last = '0;
        #1;
        check("reset_res", {r3, r2, r1, r0}, 64'h0);
        check("reset_ctl", {57'd0, rd_o, rw_o, mw_o, rs_o, bt_o, z_o}, 64'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset_stall", {63'd0, stall}, 64'd0);
        @(negedge clk);

        issue("add", 4'd0, 64'h8000_1234_FFFF_0001, 64'h8000_1111_0001_0001,
              1, 0, 0, 0, 4'd5, 0, 0);
        check("add_const", {r3, r2, r1, r0}, 64'h0000_2345_0000_0002);

        issue("sub", 4'd1, {4{16'h0007}}, {4{16'h0007}}, 1, 0, 1, 0, 4'd2, 0, 0);
        check("sub_zero_bt", {62'd0, z_o, bt_o}, 64'd3);

        issue("rol", 4'd7, {4{16'h8001}}, {4{16'h0001}}, 1, 1, 0, 1, 4'd7, 0, 0);
        check("rol_const", {r3, r2, r1, r0}, {4{16'h0003}});

        issue("mul35", 4'd9, {4{16'h0003}}, {4{16'h0005}}, 1, 0, 1, 0, 4'd9, 0, 0);
        check("mul35_const", {r3, r2, r1, r0}, {4{16'h000F}});

        issue("mulwrap", 4'd9, {4{16'hFFFF}}, {4{16'hFFFF}}, 1, 0, 0, 1, 4'd1, 0, 0);
        check("mulwrap_const", {r3, r2, r1, r0}, {4{16'h0001}});

        issue("mulstop", 4'd9, 64'h1234_00FF_0007_ABCD, 64'h0101_00FF_0009_1234,
              1, 1, 0, 0, 4'd12, 2, 3);

        for (int k = 0; k < 14; k++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (ops[k] == 4'd12) rb[15:0] = ra[15:0];
            issue($sformatf("op%0d", ops[k]), ops[k], ra, rb, 1'(k % 2), 1'(k % 3 == 0),
                  1, 1'(k % 4 == 1), 4'(k), 0, 0);
        end

        issue("mulrand", 4'd9, {$urandom, $urandom}, {$urandom, $urandom},
              1, 0, 0, 0, 4'd14, 0, 0);

        // Abort a multiply at cnt=2 with an asynchronous reset
        op_in = 4'd9; a_v = {4{16'h0011}}; b_v = {4{16'h0022}};
        rw_in = 1; mw_in = 1; rd_in = 4'hA;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midreset_res", {r3, r2, r1, r0}, 64'h0);
        check("midreset_ctl", {57'd0, rd_o, rw_o, mw_o, rs_o, bt_o, z_o}, 64'h0);
        check("midreset_stall_mul", {63'd0, stall}, 64'd1);
        op_in = 4'd0;
        #1;
        check("midreset_stall_add", {63'd0, stall}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        last = '0;
        issue("postrst_add", 4'd0, 64'h0004_0003_0002_0001, 64'h0010_0010_0010_0010,
              1, 0, 0, 0, 4'd3, 0, 0);
        issue("postrst_pass", 4'd10, 64'h0000_0000_0000_0000, 64'h1111_2222_3333_4444,
              0, 0, 0, 0, 4'd6, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
